// File: rtl/pattern_gen.sv
// Video test-pattern generator: bars, checker, ramps and solid fill, two-stage pipeline.
// Define PATTERN_ANIM_EN to scroll bars/checker one cell per frame using the frame counter.
module pattern_gen #(
  parameter int H_ACTIVE  = 1280,
  parameter int V_ACTIVE  = 720,
  parameter int BAR_SHIFT = 4,
  parameter int CW        = 8
) (
  input  logic              pxClk,
  input  logic              I_rst_n,
  input  logic [11:0]       I_hor_cnt,
  input  logic [11:0]       I_ver_cnt,
  input  logic [2:0]        I_mode,
  input  logic [3*CW-1:0]   I_solid_color,
  output logic [3*CW-1:0]   O_color,
  output logic [2:0]        O_mode_active,
  output logic [7:0]        O_frame_cnt
);

  localparam logic [2:0] MODE_BARS    = 3'd0;
  localparam logic [2:0] MODE_CHECKER = 3'd1;
  localparam logic [2:0] MODE_HRAMP   = 3'd2;
  localparam logic [2:0] MODE_VRAMP   = 3'd3;
  localparam logic [2:0] MODE_SOLID   = 3'd4;

  localparam logic [11:0] H_LIM = 12'(H_ACTIVE);
  localparam logic [11:0] V_LIM = 12'(V_ACTIVE);

  localparam logic [3*CW-1:0] COLOR_BLACK = {(3*CW){1'b0}};

  // Widen a one-bit-per-channel {B,G,R} code to full-scale channels.
  function automatic logic [3*CW-1:0] expand_bgr(input logic [2:0] bgr);
    return {{CW{bgr[2]}}, {CW{bgr[1]}}, {CW{bgr[0]}}};
  endfunction

  function automatic logic [2:0] bar_bgr(input logic [2:0] idx);
    logic [2:0] bgr;
    case (idx)
      3'd0:    bgr = 3'b111;  // white
      3'd1:    bgr = 3'b011;  // yellow
      3'd2:    bgr = 3'b110;  // cyan
      3'd3:    bgr = 3'b010;  // green
      3'd4:    bgr = 3'b101;  // magenta
      3'd5:    bgr = 3'b001;  // red
      3'd6:    bgr = 3'b100;  // blue
      default: bgr = 3'b000;  // black
    endcase
    return bgr;
  endfunction

  logic              frame_start_s;
  logic [2:0]        mode_q, mode_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic              started_q, started_d;
  logic [11:0]       hor_q, ver_q;
  logic [3*CW-1:0]   solid_q;
  logic [3*CW-1:0]   color_q, color_d;
  logic [2:0]        offset_s;
  logic [2:0]        bar_idx_s;
  logic              checker_s;
  logic              blank_s;

  assign frame_start_s = (I_hor_cnt == 12'd0) && (I_ver_cnt == 12'd0);

`ifdef PATTERN_ANIM_EN
  assign offset_s = frame_cnt_q[2:0];
`else
  assign offset_s = 3'd0;
`endif

  // Mode, frame count and started flag all change at the frame-start edge, so stage 2
  // already sees the new values while it renders pixel (0,0).
  always_comb begin
    mode_d      = mode_q;
    frame_cnt_d = frame_cnt_q;
    started_d   = started_q;
    if (frame_start_s) begin
      mode_d      = I_mode;
      frame_cnt_d = frame_cnt_q + 8'd1;
      started_d   = 1'b1;
    end else begin
      mode_d      = mode_q;
      frame_cnt_d = frame_cnt_q;
      started_d   = started_q;
    end
  end

  // Frame-level control state.
  always_ff @(posedge pxClk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      mode_q      <= 3'd0;
      frame_cnt_q <= 8'd0;
      started_q   <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      frame_cnt_q <= frame_cnt_d;
      started_q   <= started_d;
    end
  end

  // Stage 1: capture position and solid colour together.
  always_ff @(posedge pxClk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      hor_q   <= 12'd0;
      ver_q   <= 12'd0;
      solid_q <= COLOR_BLACK;
    end else begin
      hor_q   <= I_hor_cnt;
      ver_q   <= I_ver_cnt;
      solid_q <= I_solid_color;
    end
  end

  assign bar_idx_s = hor_q[BAR_SHIFT +: 3] + offset_s;
  assign checker_s = bar_idx_s[0] ^ ver_q[BAR_SHIFT];
  assign blank_s   = (hor_q >= H_LIM) || (ver_q >= V_LIM);

  // Stage 2 colour selection; nothing is shown until the first frame start arrives.
  always_comb begin
    color_d = COLOR_BLACK;
    if (!started_q || blank_s) begin
      color_d = COLOR_BLACK;
    end else begin
      case (mode_q)
        MODE_BARS:    color_d = expand_bgr(bar_bgr(bar_idx_s));
        MODE_CHECKER: color_d = checker_s ? COLOR_BLACK : expand_bgr(3'b111);
        MODE_HRAMP:   color_d = {3{hor_q[CW-1:0]}};
        MODE_VRAMP:   color_d = {3{ver_q[CW-1:0]}};
        MODE_SOLID:   color_d = solid_q;
        default:      color_d = COLOR_BLACK;
      endcase
    end
  end

  // Stage 2 output register.
  always_ff @(posedge pxClk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      color_q <= COLOR_BLACK;
    end else begin
      color_q <= color_d;
    end
  end

  assign O_color       = color_q;
  assign O_mode_active = mode_q;
  assign O_frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_pattern_gen.sv
// Directed bench for pattern_gen: reset, each mode, blanking, mode latching, counter wrap.
module tb_pattern_gen;

  logic        pxClk;
  logic        I_rst_n;
  logic [11:0] I_hor_cnt;
  logic [11:0] I_ver_cnt;
  logic [2:0]  I_mode;
  logic [23:0] I_solid_color;
  logic [23:0] O_color;
  logic [2:0]  O_mode_active;
  logic [7:0]  O_frame_cnt;

  int checks = 0;
  int errors = 0;
  int exp_frames = 0;

  pattern_gen dut (
    .pxClk         (pxClk),
    .I_rst_n       (I_rst_n),
    .I_hor_cnt     (I_hor_cnt),
    .I_ver_cnt     (I_ver_cnt),
    .I_mode        (I_mode),
    .I_solid_color (I_solid_color),
    .O_color       (O_color),
    .O_mode_active (O_mode_active),
    .O_frame_cnt   (O_frame_cnt)
  );

  initial begin
    pxClk = 1'b0;
    forever #5 pxClk = ~pxClk;
  end

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one pixel position and advance one clock.
  task automatic send(input logic [11:0] h, input logic [11:0] v);
    I_hor_cnt = h;
    I_ver_cnt = v;
    if (h == 12'd0 && v == 12'd0) exp_frames++;
    @(posedge pxClk);
    #1;
  endtask

  function automatic int off();
`ifdef PATTERN_ANIM_EN
    return exp_frames % 8;
`else
    return 0;
`endif
  endfunction

  function automatic logic [23:0] bar_exp(input int idx);
    case (idx % 8)
      0:       return 24'hFFFFFF;
      1:       return 24'h00FFFF;
      2:       return 24'hFFFF00;
      3:       return 24'h00FF00;
      4:       return 24'hFF00FF;
      5:       return 24'h0000FF;
      6:       return 24'hFF0000;
      default: return 24'h000000;
    endcase
  endfunction

  initial begin
    I_rst_n       = 1'b0;
    I_hor_cnt     = 12'd5;
    I_ver_cnt     = 12'd5;
    I_mode        = 3'd0;
    I_solid_color = 24'h000000;
    #3;
    chk("reset_color", O_color, 24'h000000);
    chk("reset_mode", {21'd0, O_mode_active}, 24'd0);
    chk("reset_fcnt", {16'd0, O_frame_cnt}, 24'd0);
    @(posedge pxClk);
    #1;
    I_rst_n = 1'b1;

    // Before the first frame start everything is black.
    send(12'd0, 12'd10);
    send(12'd16, 12'd10);
    chk("pre_frame_h0", O_color, 24'h000000);
    send(12'd32, 12'd10);
    chk("pre_frame_h16", O_color, 24'h000000);

    // Colour bars.
    I_mode = 3'd0;
    send(12'd0, 12'd0);
    chk("fcnt_first", {16'd0, O_frame_cnt}, 24'd1);
    chk("mode_bars", {21'd0, O_mode_active}, 24'd0);
    send(12'd0, 12'd10);
    chk("bars_px00", O_color, bar_exp(off()));
    send(12'd16, 12'd10);
    chk("bars_h0", O_color, bar_exp(off()));
    send(12'd112, 12'd10);
    chk("bars_h16", O_color, bar_exp(1 + off()));
    send(12'd200, 12'd10);
    chk("bars_h112", O_color, bar_exp(7 + off()));

    // Checker.
    I_mode = 3'd1;
    send(12'd0, 12'd0);
    chk("mode_checker", {21'd0, O_mode_active}, 24'd1);
    send(12'd16, 12'd0);
    send(12'd16, 12'd16);
    chk("checker_16_0", O_color, (((1 + off()) % 2) == 0) ? 24'hFFFFFF : 24'h000000);
    send(12'd40, 12'd40);
    chk("checker_16_16", O_color, (((1 + off()) % 2) == 1) ? 24'hFFFFFF : 24'h000000);

    // Horizontal ramp and blanking.
    I_mode = 3'd2;
    send(12'd0, 12'd0);
    send(12'd300, 12'd5);
    send(12'd1280, 12'd5);
    chk("hramp_300", O_color, 24'h2C2C2C);
    send(12'd10, 12'd5);
    chk("hblank_1280", O_color, 24'h000000);
    send(12'd10, 12'd720);
    chk("hramp_10", O_color, 24'h0A0A0A);
    send(12'd10, 12'd5);
    chk("vblank_720", O_color, 24'h000000);

    // Vertical ramp.
    I_mode = 3'd3;
    send(12'd0, 12'd0);
    send(12'd7, 12'd427);
    send(12'd8, 12'd1);
    chk("vramp_427", O_color, 24'hABABAB);

    // Mid-frame mode change is held off until the next frame start.
    I_mode = 3'd0;
    send(12'd0, 12'd0);
    send(12'd500, 12'd100);
    I_mode = 3'd4;
    I_solid_color = 24'h123456;
    send(12'd16, 12'd100);
    chk("bars_h500", O_color, bar_exp(31 + off()));
    send(12'd17, 12'd100);
    chk("midframe_ignored", O_color, bar_exp(1 + off()));
    chk("midframe_mode", {21'd0, O_mode_active}, 24'd0);
    send(12'd0, 12'd0);
    chk("mode_solid", {21'd0, O_mode_active}, 24'd4);
    send(12'd1, 12'd0);
    chk("solid_px00", O_color, 24'h123456);
    I_solid_color = 24'hAABBCC;
    send(12'd2, 12'd0);
    chk("solid_px10", O_color, 24'h123456);
    send(12'd3, 12'd0);
    chk("solid_px20", O_color, 24'hAABBCC);

    // Reserved mode.
    I_mode = 3'd5;
    send(12'd0, 12'd0);
    send(12'd100, 12'd100);
    send(12'd101, 12'd100);
    chk("reserved_black", O_color, 24'h000000);

    // Frame counter wraps after 256 frame starts.
    I_mode = 3'd0;
    begin
      int n;
      n = 256 - exp_frames;
      for (int i = 0; i < n; i++) begin
        send(12'd0, 12'd0);
        send(12'd1, 12'd0);
      end
    end
    chk("fcnt_wrap", {16'd0, O_frame_cnt}, 24'd0);

    // Asynchronous reset mid-line.
    I_mode = 3'd4;
    I_solid_color = 24'h5A5A5A;
    send(12'd0, 12'd0);
    send(12'd700, 12'd100);
    send(12'd701, 12'd100);
    chk("pre_rst_color", O_color, 24'h5A5A5A);
    chk("pre_rst_fcnt", {16'd0, O_frame_cnt}, 24'd1);
    #2;
    I_rst_n = 1'b0;
    #1;
    chk("async_rst_color", O_color, 24'h000000);
    chk("async_rst_mode", {21'd0, O_mode_active}, 24'd0);
    chk("async_rst_fcnt", {16'd0, O_frame_cnt}, 24'd0);
    @(posedge pxClk);
    #1;
    I_rst_n = 1'b1;
    send(12'd5, 12'd5);
    send(12'd6, 12'd5);
    chk("post_rst_black", O_color, 24'h000000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
